interval_binner: RTL and testbench

- Streaming floating-point interval classifier with programmable boundaries and per-bin histogram counters.
- Accepts one scalar per cycle over valid/ready and compares it against NumBins-1 run-time-writable boundaries.
- Emits the one-hot bin, the bin index and a NaN flag, and counts delivered samples per bin.
- Sits after the fpnew datapath as the quantisation/statistics stage for activation ranges.

---
 rtl/interval_pkg.sv | 103 ++++++++++
 rtl/interval_fp_ge.sv | 20 ++
 rtl/interval_binner.sv | 165 ++++++++++++++++
 tb/tb_interval_binner.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interval_pkg.sv
// interval_pkg: shared types and floating-point helpers for interval_binner.
//
// Contents:
//   fp_format_e   - floating-point format selector (same encoding as
//                   fpnew_pkg::fp_format_e, so a value of 2 selects FP16)
//   fp_width/exp_bits/man_bits - format geometry helpers
//   binner_res_t  - classification result {onehot, index, nan}
//   is_nan/fp_ge  - IEEE NaN test and ">=" compare on values zero-extended
//                   to MaxW bits, parametrised by the format
package interval_pkg;

  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4
  } fp_format_e;

  // Widest supported format and the largest bin count the result struct can hold.
  localparam int unsigned MaxW    = 64;
  localparam int unsigned MaxBins = 64;
  localparam int unsigned MaxIdxW = 6;

  localparam logic [MaxW-1:0] FpOne = MaxW'(1);

  // Result carried through the output stage. It is sized for MaxBins; a binner
  // with fewer bins leaves the upper onehot/index bits at zero.
  typedef struct packed {
    logic [MaxBins-1:0] onehot;
    logic [MaxIdxW-1:0] index;
    logic               nan;
  } binner_res_t;

  function automatic int unsigned fp_width(input fp_format_e fmt);
    case (fmt)
      FP32:    return 32;
      FP64:    return 64;
      FP16:    return 16;
      FP8:     return 8;
      FP16ALT: return 16;
      default: return 16;
    endcase
  endfunction

  function automatic int unsigned exp_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 8;
      FP64:    return 11;
      FP16:    return 5;
      FP8:     return 5;
      FP16ALT: return 8;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned man_bits(input fp_format_e fmt);
    case (fmt)
      FP32:    return 23;
      FP64:    return 52;
      FP16:    return 10;
      FP8:     return 2;
      FP16ALT: return 7;
      default: return 10;
    endcase
  endfunction

  // NaN: exponent all ones and a non-zero mantissa.
  function automatic logic is_nan(input logic [MaxW-1:0] v, input fp_format_e fmt);
    logic [MaxW-1:0] man_mask;
    logic [MaxW-1:0] exp_mask;
    man_mask = (FpOne << man_bits(fmt)) - FpOne;
    exp_mask = ((FpOne << exp_bits(fmt)) - FpOne) << man_bits(fmt);
    return ((v & exp_mask) == exp_mask) && ((v & man_mask) != '0);
  endfunction

  // a >= b under IEEE ordering: NaN on either side gives 0, -0 equals +0,
  // infinities order naturally because their encoding is the largest magnitude.
  function automatic logic fp_ge(input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                                 input fp_format_e fmt);
    logic [MaxW-1:0] mag_mask;
    logic [MaxW-1:0] mag_a;
    logic [MaxW-1:0] mag_b;
    logic [MaxW-1:0] a_sh;
    logic [MaxW-1:0] b_sh;
    logic            sa;
    logic            sb;
    if (is_nan(a, fmt) || is_nan(b, fmt)) return 1'b0;
    mag_mask = (FpOne << (fp_width(fmt) - 1)) - FpOne;
    mag_a    = a & mag_mask;
    mag_b    = b & mag_mask;
    a_sh     = a >> (fp_width(fmt) - 1);
    b_sh     = b >> (fp_width(fmt) - 1);
    sa       = a_sh[0];
    sb       = b_sh[0];
    if ((mag_a == '0) && (mag_b == '0)) return 1'b1;
    if (sa != sb) return !sa;
    // Same sign: sign-magnitude order flips for negatives.
    if (!sa) return mag_a >= mag_b;
    return mag_a <= mag_b;
  endfunction

endpackage

// File: rtl/interval_fp_ge.sv
// interval_fp_ge: combinational IEEE "a >= b" comparator for one boundary.
//
// Ports:
//   a_i  - sample (WIDTH bits)
//   b_i  - boundary (WIDTH bits)
//   ge_o - 1 when a_i >= b_i; 0 whenever either operand is NaN
module interval_fp_ge
  import interval_pkg::*;
#(
  parameter fp_format_e FpFormat = FP16,
  localparam int unsigned WIDTH  = fp_width(FpFormat)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ge_o
);

  assign ge_o = fp_ge(MaxW'(a_i), MaxW'(b_i), FpFormat);

endmodule

// File: rtl/interval_binner.sv
// interval_binner: streaming floating-point interval classifier with
// run-time boundaries and per-bin saturating histogram counters.
//
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   cfg_we_i/addr_i/data_i   - boundary write port (index >= NumBins-1 ignored)
//   in_valid_i/in_ready_o/s_i- sample stream
//   out_valid_o/out_ready_i  - result stream
//   interval_o, index_o      - one-hot bin and bin index (zero for NaN)
//   nan_o                    - sample was NaN
//   clr_i                    - synchronous clear of all counters
//   cnt_sel_i/cnt_o          - combinational counter read
//
// Two-stage pipeline: P1 holds the boundary compare vector and NaN flag,
// P2 holds the encoded result. Bin index is the popcount of the compare
// vector, so non-monotonic boundary sets still give a defined bin.
module interval_binner
  import interval_pkg::*;
#(
  parameter fp_format_e  FpFormat = FP16,
  parameter int unsigned NumBins  = 8,
  parameter int unsigned CntWidth = 16,
  localparam int unsigned WIDTH   = fp_width(FpFormat),
  localparam int unsigned IdxW    = $clog2(NumBins),
  localparam int unsigned AddrW   = (NumBins > 2) ? $clog2(NumBins - 1) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [AddrW-1:0]    cfg_addr_i,
  input  logic [WIDTH-1:0]    cfg_data_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [WIDTH-1:0]    s_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [NumBins-1:0]  interval_o,
  output logic [IdxW-1:0]     index_o,
  output logic                nan_o,
  input  logic                clr_i,
  input  logic [IdxW-1:0]     cnt_sel_i,
  output logic [CntWidth-1:0] cnt_o
);

  localparam int unsigned NumBnd = NumBins - 1;

  if ((NumBins < 2) || (NumBins > MaxBins)) begin : g_bad_numbins
    $error("interval_binner: NumBins out of range");
  end

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] c);
    return (c == '1) ? c : c + CntWidth'(1);
  endfunction

  logic [WIDTH-1:0]    bnd_q [NumBnd];
  logic [NumBnd-1:0]   ge_d;
  logic                nan_d;
  logic [NumBnd-1:0]   ge_p1;
  logic                nan_p1;
  logic                vld_p1;
  logic                vld_p2;
  logic                adv_p1;
  logic                adv_p2;
  logic                accept;
  logic                deliver;
  logic [IdxW-1:0]     popcnt;
  binner_res_t         res_d;
  binner_res_t         res_p2;
  logic [CntWidth-1:0] cnt_q [NumBins];

  // Boundary registers; a write lands at the clock edge, so a sample accepted
  // in the same cycle still compares against the old value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumBnd; k++) bnd_q[k] <= '0;
    end else if (cfg_we_i) begin
      for (int unsigned k = 0; k < NumBnd; k++) begin
        if (cfg_addr_i == AddrW'(k)) bnd_q[k] <= cfg_data_i;
      end
    end
  end

  for (genvar k = 0; k < NumBnd; k++) begin : g_cmp
    interval_fp_ge #(
      .FpFormat(FpFormat)
    ) u_ge (
      .a_i (s_i),
      .b_i (bnd_q[k]),
      .ge_o(ge_d[k])
    );
  end

  assign nan_d = is_nan(MaxW'(s_i), FpFormat);

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv_p2     = !vld_p2 || out_ready_i;
  assign adv_p1     = !vld_p1 || adv_p2;
  assign in_ready_o = adv_p1;
  assign accept     = in_valid_i && adv_p1;
  assign deliver    = vld_p2 && out_ready_i;

  // ---- stage P1: compare vector and NaN flag ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p1 <= 1'b0;
    end else if (adv_p1) begin
      vld_p1 <= in_valid_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      ge_p1  <= ge_d;
      nan_p1 <= nan_d;
    end
  end

  always_comb begin
    popcnt = '0;
    for (int unsigned k = 0; k < NumBnd; k++) popcnt = popcnt + IdxW'(ge_p1[k]);
    res_d     = '0;
    res_d.nan = nan_p1;
    if (!nan_p1) begin
      res_d.index  = MaxIdxW'(popcnt);
      res_d.onehot = MaxBins'(1) << popcnt;
    end
  end

  // ---- stage P2: encoded result, held while the consumer stalls ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p2 <= 1'b0;
      res_p2 <= '0;
    end else if (adv_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) res_p2 <= res_d;
    end
  end

  assign out_valid_o = vld_p2;
  assign interval_o  = res_p2.onehot[NumBins-1:0];
  assign index_o     = res_p2.index[IdxW-1:0];
  assign nan_o       = res_p2.nan;

  // ---- histogram: count delivered non-NaN results (empty onehot means NaN) ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NumBins; k++) cnt_q[k] <= '0;
    end else if (clr_i) begin
      for (int unsigned k = 0; k < NumBins; k++) cnt_q[k] <= '0;
    end else if (deliver && (|res_p2.onehot)) begin
      for (int unsigned k = 0; k < NumBins; k++) begin
        if (res_p2.index == MaxIdxW'(k)) cnt_q[k] <= sat_inc(cnt_q[k]);
      end
    end
  end

  always_comb begin
    cnt_o = '0;
    for (int unsigned k = 0; k < NumBins; k++) begin
      if (cnt_sel_i == IdxW'(k)) cnt_o = cnt_q[k];
    end
  end

endmodule

// File: tb/tb_interval_binner.sv
module tb_interval_binner;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       nan;
    logic [2:0] idx;
    logic [7:0] oh;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] s;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  interval;
  logic [2:0]  index;
  logic        nan;
  logic        clr;
  logic [2:0]  cnt_sel;
  logic [3:0]  cnt;

  int          checks = 0;
  int          errors = 0;
  int          n_del  = 0;
  logic [15:0] bm [7];
  int          cm [8];
  exp_t        q [$];

  interval_binner #(
    .FpFormat(interval_pkg::FP16),
    .NumBins (8),
    .CntWidth(CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cfg_we_i   (cfg_we),
    .cfg_addr_i (cfg_addr),
    .cfg_data_i (cfg_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .s_i        (s),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .interval_o (interval),
    .index_o    (index),
    .nan_o      (nan),
    .clr_i      (clr),
    .cnt_sel_i  (cnt_sel),
    .cnt_o      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic bit h_isnan(input logic [15:0] h);
    return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
  endfunction

  function automatic real h_val(input logic [15:0] h);
    real mag;
    int  e;
    e = int'(h[14:10]);
    if (e == 31)     mag = 1.0e30;
    else if (e == 0) mag = real'(int'(h[9:0])) * pow2(-24);
    else             mag = (1024.0 + real'(int'(h[9:0]))) * pow2(e - 25);
    return h[15] ? -mag : mag;
  endfunction

  function automatic exp_t model(input logic [15:0] sv);
    exp_t e;
    int   n;
    e = '0;
    if (h_isnan(sv)) begin
      e.nan = 1'b1;
      return e;
    end
    n = 0;
    for (int k = 0; k < 7; k++)
      if (!h_isnan(bm[k]) && (h_val(sv) >= h_val(bm[k]))) n++;
    e.idx = 3'(n);
    e.oh  = 8'(1 << n);
    return e;
  endfunction

  function automatic exp_t mk(input int xi);
    exp_t e;
    e = '0;
    if (xi == 8) e.nan = 1'b1;
    else begin
      e.idx = 3'(xi);
      e.oh  = 8'(1 << xi);
    end
    return e;
  endfunction

  function automatic logic [15:0] rnd_fp();
    case ($urandom_range(0, 11))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7C00;
      3:       return 16'hFC00;
      4:       return 16'h7E00;
      5:       return 16'h3C00;
      6:       return 16'h3E00;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic prev_stall;
    exp_t prev;
    exp_t e;
    logic popped;
    prev_stall = 1'b0;
    prev       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        checks++;
        if (cnt !== 4'(cm[cnt_sel])) begin
          errors++;
          $display("FAIL cnt_o sel=%0d: got %0d expected %0d", cnt_sel, cnt, cm[cnt_sel]);
        end
        if (prev_stall) begin
          checks++;
          if (!out_valid || ({nan, index, interval} !== prev)) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b %03h expected v=1 %03h",
                     out_valid, {nan, index, interval}, prev);
          end
        end
        popped = 1'b0;
        e      = '0;
        if (out_valid && out_ready) begin
          checks++;
          n_del++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL result: got unexpected output %03h expected none", {nan, index, interval});
          end else begin
            e      = q.pop_front();
            popped = 1'b1;
            if ({nan, index, interval} !== e) begin
              errors++;
              $display("FAIL result: got nan=%0b idx=%0d oh=%02h expected nan=%0b idx=%0d oh=%02h",
                       nan, index, interval, e.nan, e.idx, e.oh);
            end
          end
        end
        if (clr) begin
          for (int k = 0; k < 8; k++) cm[k] = 0;
        end else if (popped && !e.nan && (cm[e.idx] < CNT_MAX)) begin
          cm[e.idx] = cm[e.idx] + 1;
        end
        prev_stall = out_valid && !out_ready;
        prev       = {nan, index, interval};
      end
    end
  end

  // ---------------- driver ----------------
  // Drives one cycle (inputs set 1 time unit after the rising edge), then
  // samples 4 units later: predicts in_ready and records any acceptance.
  task automatic drive(input logic v, input logic [15:0] sv, input logic ordy,
                       input logic we, input logic [2:0] a, input logic [15:0] d,
                       input logic c, input logic [2:0] sel, input int xi,
                       output logic acc);
    @(posedge clk);
    #1;
    in_valid  = v;
    s         = sv;
    out_ready = ordy;
    cfg_we    = we;
    cfg_addr  = a;
    cfg_data  = d;
    clr       = c;
    cnt_sel   = sel;
    #3;
    acc = 1'b0;
    if (rst_n) begin
      chk("in_ready", 32'(in_ready), 32'(!((q.size() == 2) && !ordy)));
      if (in_valid && in_ready) begin
        acc = 1'b1;
        q.push_back((xi < 0) ? model(sv) : mk(xi));
      end
      if (we && (a < 3'd7)) bm[a] = d;
    end
  endtask

  task automatic send(input logic [15:0] sv, input int xi, input logic [2:0] sel);
    logic acc;
    acc = 1'b0;
    for (int n = 0; (n < 50) && !acc; n++) drive(1'b1, sv, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, sel, xi, acc);
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain(input logic [2:0] sel);
    logic acc;
    for (int n = 0; (n < 20) && (q.size() != 0); n++)
      drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, sel, -1, acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin : driver
    logic        acc;
    logic        saw_low;
    int          i;
    int          d0;
    logic [15:0] bnds [7];
    logic [15:0] smp [6];

    bnds = '{16'hBC00, 16'h0000, 16'h3800, 16'h3C00, 16'h4000, 16'h4400, 16'h4800};
    smp  = '{16'h3E00, 16'h8000, 16'h3C00, 16'hFC00, 16'h7C00, 16'h4200};
    for (int k = 0; k < 7; k++) bm[k] = 16'h0;
    for (int k = 0; k < 8; k++) cm[k] = 0;
    rst_n = 1'b0; in_valid = 1'b0; s = 16'h0; out_ready = 1'b0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 16'h0; clr = 1'b0; cnt_sel = 3'd0;

    repeat (2) @(posedge clk);
    #4;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_interval", 32'(interval), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
    chk("rst_nan", 32'(nan), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Boundaries -1, 0, 0.5, 1, 2, 4, 8 and the edge samples.
    for (int k = 0; k < 7; k++) drive(1'b0, 16'h0, 1'b1, 1'b1, 3'(k), bnds[k], 1'b0, 3'd0, -1, acc);
    send(16'h3E00, 4, 3'd0);
    send(16'h8000, 2, 3'd0);
    send(16'h3C00, 4, 3'd0);
    send(16'hFC00, 0, 3'd0);
    send(16'h7C00, 7, 3'd0);
    drain(3'd0);
    chk("cnt0_before_nan", 32'(cnt), 32'd1);
    send(16'h7E00, 8, 3'd0);
    drain(3'd0);
    chk("cnt0_after_nan", 32'(cnt), 32'd1);

    // Six back-to-back samples, consumer stalled for cycles 3..5.
    i = 0; saw_low = 1'b0; d0 = n_del;
    for (int c = 0; (c < 40) && (i < 6); c++) begin
      drive(1'b1, smp[i], !((c >= 3) && (c <= 5)), 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, -1, acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) i++;
    end
    chk("stall_all_accepted", 32'(i), 32'd6);
    chk("stall_in_ready_dropped", 32'(saw_low), 32'd1);
    drain(3'd0);
    chk("stall_delivered", 32'(n_del - d0), 32'd6);

    // Boundary write coinciding with acceptance: old value used, new value next.
    drive(1'b1, 16'h3E00, 1'b1, 1'b1, 3'd3, 16'h4000, 1'b0, 3'd0, 4, acc);
    chk("wr_same_cycle_acc", 32'(acc), 32'd1);
    send(16'h3E00, 3, 3'd0);
    drain(3'd0);
    drive(1'b0, 16'h0, 1'b1, 1'b1, 3'd3, 16'h3C00, 1'b0, 3'd0, -1, acc);

    // Saturation at 15 and clear beating a same-cycle increment.
    drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, -1, acc);
    for (int n = 0; n < 20; n++) send(16'h4200, 5, 3'd5);
    drain(3'd5);
    chk("cnt5_saturated", 32'(cnt), 32'd15);
    drive(1'b1, 16'h4200, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd5, 5, acc);
    chk("clr_sample_acc", 32'(acc), 32'd1);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd5, -1, acc);
    drive(1'b0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd5, -1, acc);
    chk("clr_out_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, -1, acc);
    drive(1'b0, 16'h0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd5, -1, acc);
    chk("cnt5_cleared", 32'(cnt), 32'd0);

    // Randomised traffic, boundary writes, clears and backpressure.
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, rnd_fp(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), rnd_fp(),
            $urandom_range(0, 39) == 0, 3'($urandom_range(0, 7)), -1, acc);
    end
    drain(3'd0);

    // Reset with samples in flight drops them and restores +0.0 boundaries.
    drive(1'b1, 16'h3E00, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd2, -1, acc);
    drive(1'b1, 16'hBC00, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd2, -1, acc);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    q.delete();
    for (int k = 0; k < 7; k++) bm[k] = 16'h0;
    for (int k = 0; k < 8; k++) cm[k] = 0;
    #3;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(16'h3E00, 7, 3'd7);
    send(16'h8000, 7, 3'd7);
    send(16'hBC00, 0, 3'd7);
    drain(3'd7);
    chk("post_rst_cnt7", 32'(cnt), 32'd2);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
